// File: rtl/full_match_stream_reader.sv
// full_match_stream_reader
// Streams the entries of one bx page of a FullMatch memory out on a
// valid/ready interface, in address order 0..N-1. BRAM read latency is
// absorbed by a skid FIFO of depth RAM_LAT+2; the read-issue gate keeps
// (issued - accepted) within that depth so the FIFO never overflows.
// Optional feature macro: FM_READER_PROFILE_EN adds the stall_cycles counter.
//
// Handshake: a beat transfers on a rising clk edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, m_valid/m_data/m_last hold.
module full_match_stream_reader #(
  parameter int DATA_W  = 45,
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        bx_in,
  output logic              busy,
  output logic              done,
  output logic [2:0]        bx_out,
  output logic              fm_dataarray_data_V_enb,
  output logic [ADDR_W-1:0] fm_dataarray_data_V_readaddr,
  input  logic [DATA_W-1:0] fm_dataarray_data_V_dout,
  input  logic [7:0]        fm_nentries_0_V_dout,
  input  logic [7:0]        fm_nentries_1_V_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef FM_READER_PROFILE_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int         FD    = RAM_LAT + 2;
  localparam logic [7:0] FD8   = 8'(FD);
  localparam logic [7:0] MAX_N = 8'd128;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FIN} state_t;

  state_t             state;
  logic               page;
  logic [2:0]         bx_lat;
  logic [7:0]         n_lat;
  logic [7:0]         issue_idx;
  logic [7:0]         accept_idx;
  logic [7:0]         outstanding;
  logic [7:0]         n_sel;
  logic [7:0]         n_sat;
  logic [RAM_LAT-1:0] dl;
  logic               push;
  logic               accept;
  logic [DATA_W-1:0]  mem [FD];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         count;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FD - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue gate, address, FIFO head presentation and handshake decode
  always_comb begin
    n_sel       = bx_in[0] ? fm_nentries_1_V_dout : fm_nentries_0_V_dout;
    n_sat       = (n_sel > MAX_N) ? MAX_N : n_sel;
    outstanding = issue_idx - accept_idx;
    fm_dataarray_data_V_enb      = (state == S_READ) && (issue_idx < n_lat) &&
                                   (outstanding < FD8);
    fm_dataarray_data_V_readaddr = {page, (ADDR_W-1)'(issue_idx)};
    m_valid = (count != 3'd0);
    m_data  = m_valid ? mem[rd_ptr] : '0;
    accept  = m_valid && m_ready;
    m_last  = m_valid && (accept_idx == n_lat - 8'd1);
    push    = dl[RAM_LAT-1];
  end

  // Control FSM: run latching, issue/accept counters, registered busy/done/bx_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bx_out     <= 3'd0;
      page       <= 1'b0;
      bx_lat     <= 3'd0;
      n_lat      <= 8'd0;
      issue_idx  <= 8'd0;
      accept_idx <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bx_lat     <= bx_in;
            page       <= bx_in[0];
            n_lat      <= n_sat;
            issue_idx  <= 8'd0;
            accept_idx <= 8'd0;
            if (n_sat == 8'd0) begin
              state  <= S_FIN;
              done   <= 1'b1;
              bx_out <= bx_in;
            end else begin
              state <= S_READ;
              busy  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (fm_dataarray_data_V_enb) issue_idx <= issue_idx + 8'd1;
          if (accept) begin
            accept_idx <= accept_idx + 8'd1;
            if (accept_idx == n_lat - 8'd1) begin
              state  <= S_FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              bx_out <= bx_lat;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Enable delay line matching BRAM latency; its tail marks valid read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl <= '0;
    end else begin
      dl[0] <= fm_dataarray_data_V_enb;
      for (int i = 1; i < RAM_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (accept) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {2'b00, push} - {2'b00, accept};
    end
  end

  // Skid FIFO storage; the head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fm_dataarray_data_V_dout;
  end

`ifdef FM_READER_PROFILE_EN
  // Saturating count of stalled valid cycles in the current/last run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
    end else if (state == S_IDLE && start) begin
      stall_cycles <= 16'd0;
    end else if (state == S_READ && m_valid && !m_ready &&
                 stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_full_match_stream_reader.sv
// tb_full_match_stream_reader
// Drives runs against a behavioural BRAM + nentries model. The expected beat
// stream of each run (page contents 0..min(N,128)-1) and its bx are queued
// at start; a negedge monitor pops and compares on every accepted beat/done.
module tb_full_match_stream_reader;

  localparam int DATA_W  = 45;
  localparam int ADDR_W  = 8;
  localparam int RAM_LAT = 1;
  localparam int FD      = RAM_LAT + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        bx_in;
  logic              busy, done;
  logic [2:0]        bx_out;
  logic              enb;
  logic [ADDR_W-1:0] readaddr;
  logic [DATA_W-1:0] dout;
  logic [7:0]        n0, n1;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_ready, m_last;
`ifdef FM_READER_PROFILE_EN
  logic [15:0]       stall_cycles;
`endif

  full_match_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .bx_in(bx_in),
    .busy(busy), .done(done), .bx_out(bx_out),
    .fm_dataarray_data_V_enb(enb),
    .fm_dataarray_data_V_readaddr(readaddr),
    .fm_dataarray_data_V_dout(dout),
    .fm_nentries_0_V_dout(n0), .fm_nentries_1_V_dout(n1),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef FM_READER_PROFILE_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- BRAM model ----------------
  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] pipe [RAM_LAT];
  always @(posedge clk) begin
    if (enb) pipe[0] <= ram[readaddr];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dout = pipe[RAM_LAT-1];

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              last_q[$];
  logic [2:0]        done_q[$];
  int n_tests = 0, n_fail = 0;
  int c0, iss, acc, stall_cnt, first_enb, first_valid, last_rel, done_rel;
  bit done_seen, prev_stall, cur_page;
  logic [DATA_W-1:0] prev_data;
  int rmode = 0;
  int ph = 0;
  logic [3:0] pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- m_ready driver ----------------
  always @(posedge clk) begin
    #1;
    ph++;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = pat[ph[1:0]];
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DATA_W-1:0] ed;
    logic              el;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (enb) begin
        if (first_enb < 0) first_enb = cyc - c0;
        check("enb_only_when_busy", busy, 1);
        check("readaddr", readaddr, {cur_page, 7'(iss)});
        check("outstanding_bound", (iss - acc) < FD, 1);
        iss++;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc - c0;
        if (m_ready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            ed = exp_q.pop_front();
            el = last_q.pop_front();
            check("m_data", m_data, ed);
            check("m_last", m_last, el);
          end
          if (m_last) last_rel = cyc - c0;
          acc++;
        end else begin
          stall_cnt++;
        end
      end else begin
        check("m_last_without_valid", m_last, 0);
      end
      if (done) begin
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) check("bx_out", bx_out, done_q.pop_front());
        check("busy_low_at_done", busy, 0);
        done_rel  = cyc - c0;
        done_seen = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Issue a start in the current cycle (called at posedge+1) and queue expectations.
  task automatic launch(input logic [2:0] bx, input logic [7:0] a0, input logic [7:0] a1,
                        input int mode, output int n);
    int raw;
    n0 = a0; n1 = a1; bx_in = bx; start = 1'b1;
    raw = bx[0] ? int'(a1) : int'(a0);
    n = (raw > 128) ? 128 : raw;
    cur_page = bx[0];
    rmode = mode; ph = 0;
    c0 = cyc; iss = 0; acc = 0; stall_cnt = 0;
    first_enb = -1; first_valid = -1; last_rel = -1; done_rel = -1; done_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ram[{bx[0], 7'(i)}]);
      last_q.push_back(i == n - 1);
    end
    done_q.push_back(bx);
  endtask

  task automatic run(input logic [2:0] bx, input logic [7:0] a0, input logic [7:0] a1,
                     input int mode, input bit timing, input bit poke);
    int n;
    int k;
    launch(bx, a0, a1, mode, n);
    k = 0;
    while (!done_seen && k < 3000) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        start = 1'b0;
        n0 = 8'($urandom); n1 = 8'($urandom);
      end
      if (poke && k == 4) begin start = 1'b1; bx_in = bx ^ 3'b110; end
      if (poke && k == 5) start = 1'b0;
    end
    check("done_seen", done_seen, 1);
    check("enb_count", iss, n);
    check("beat_count", acc, n);
`ifdef FM_READER_PROFILE_EN
    check("stall_cycles", stall_cycles, stall_cnt);
`endif
    if (timing) begin
      if (n == 0) begin
        check("done_cycle_empty", done_rel, 1);
        check("no_valid_empty", first_valid, -1);
      end else begin
        check("first_enb_cycle", first_enb, 1);
        check("first_valid_cycle", first_valid, 2 + RAM_LAT);
        check("last_beat_cycle", last_rel, n + RAM_LAT + 1);
        check("done_cycle", done_rel, n + RAM_LAT + 2);
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int k;
    reset = 1'b1; start = 1'b0; bx_in = 3'd0; n0 = 8'd0; n1 = 8'd0; m_ready = 1'b1;
    c0 = 0; iss = 0; acc = 0; stall_cnt = 0; done_seen = 1'b0;
    first_enb = -1; first_valid = -1; last_rel = -1; done_rel = -1;
    for (int i = 0; i < 256; i++) ram[i] = DATA_W'({$urandom, $urandom});
    for (int i = 0; i < RAM_LAT; i++) pipe[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bx_out", bx_out, 0);
    check("rst_enb", enb, 0);
    check("rst_readaddr", readaddr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // page 1, five entries, full throughput
    run(3'd3, 8'd17, 8'd5, 0, 1, 0);
    // empty page
    run(3'd4, 8'd0, 8'd9, 0, 1, 0);
    // six entries with 1,0,0,1 backpressure
    run(3'd2, 8'd6, 8'd1, 1, 0, 0);
    // oversize count saturates to 128
    run(3'd0, 8'd200, 8'd3, 0, 1, 0);
    // start pulsed mid-run is ignored
    run(3'd7, 8'd2, 8'd20, 2, 0, 1);

    // reset after four beats of a ten-entry run
    launch(3'd6, 8'd10, 8'd4, 0, n);
    k = 0;
    while (acc < 4 && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) start = 1'b0;
    end
    check("reached_four_beats", acc >= 4, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bx_out", bx_out, 0);
    check("mid_rst_enb", enb, 0);
    check("mid_rst_readaddr", readaddr, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_m_data", m_data, 0);
    exp_q.delete(); last_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen, 0);
    run(3'd1, 8'd0, 8'd10, 0, 1, 0);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [7:0] a0, a1;
      int mode;
      a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(129, 255)) : 8'($urandom_range(0, 40));
      a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(129, 255)) : 8'($urandom_range(0, 40));
      mode = $urandom_range(0, 2);
      run(3'($urandom), a0, a1, mode, mode == 0, 0);
    end

    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/full_match_stream_reader.md
# full_match_stream_reader

Reads one bx page of a FullMatch memory, the kind the MatchCalculator fills via `fullmatch*_dataarray` writes plus `nentries_*` strobes, and streams its entries out on a valid/ready interface. It sits downstream of the FM memories and feeds track-building or readout logic. It is the read-side counterpart of the MatchCalculator FM write port. It absorbs BRAM read latency with a small skid FIFO so downstream backpressure never loses data.

## Interface
Parameters:
- `DATA_W`, default 45: FM entry width.
- `ADDR_W`, default 8: FM address width. The MSB selects the page, so each page holds 2^(ADDR_W-1) = 128 entries.
- `RAM_LAT`, default 1: BRAM read latency in cycles. Legal values are 1 and 2.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: run request. Sampled only in IDLE.
- `bx_in` in 3: bx to read. `bx_in[0]` selects the page.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse when the run is complete.
- `bx_out` out 3: bx of the last completed run. Updated together with `done`.
- `fm_dataarray_data_V_enb` out 1: memory read enable.
- `fm_dataarray_data_V_readaddr` out ADDR_W: read address, `{page, idx}`.
- `fm_dataarray_data_V_dout` in DATA_W: read data, valid RAM_LAT cycles after `enb`.
- `fm_nentries_0_V_dout` in 8: entry count for page 0.
- `fm_nentries_1_V_dout` in 8: entry count for page 1.
- `m_data` out DATA_W: stream data, taken from the FIFO head.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: high with the final beat of the run.
- `stall_cycles` out 16: present only with `FM_READER_PROFILE_EN`.

## Operation
- FSM has three states: IDLE, READ, FIN.
- **IDLE:**
  - On `start`, latch `bx_in` and page = `bx_in[0]`.
  - Latch N = the selected `nentries`, saturated to 128.
  - Clear the issue and accept counters. Go to FIN if N==0, otherwise to READ.
  - `start` is ignored in every other state.
- **READ:**
  - Assert `enb` with `readaddr = {page, issue_idx}` whenever issue_idx < N and (issued − accepted) < FIFO depth (RAM_LAT+2).
  - issue_idx increments on every asserted `enb`.
  - A delay line of RAM_LAT stages carries the enable. When it emerges, `dout` is pushed into the FIFO.
  - A beat is accepted when `m_valid && m_ready`. This increments accept_idx.
  - `m_last` = `m_valid && (accept_idx == N−1)`.
  - After the last beat is accepted, go to FIN.
- **FIN:** pulse `done`, set `bx_out` to the latched bx, return to IDLE. `busy` drops in the same cycle.
- The FIFO can never overflow: the issue gate enforces this, not the consumer.
- Data order equals address order: 0..N−1.
- `enb` is never asserted outside READ.
- Reset values: `busy`=0, `done`=0, `bx_out`=0, `enb`=0, `readaddr`=0, `m_valid`=0, `m_last`=0, `m_data`=0, FIFO empty, state IDLE.
- **Reset mid-run:** all state clears immediately. No `done` is emitted, and in-flight BRAM data is discarded via the cleared delay line.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- Cycle 1: first `enb` (N>0).
- Cycle 2+RAM_LAT: first `m_valid`. With RAM_LAT=1 this is cycle 3.
- With `m_ready` held high: one beat per cycle, no bubbles, and `enb` is asserted on every cycle 1..N.
- Last beat at cycle N+RAM_LAT+1.
- `done` at cycle N+RAM_LAT+2, then IDLE. A new `start` is accepted in the next cycle.
- N==0: `done` at cycle 1, no `enb`, no `m_valid`.
- N>128: only 128 entries are read (addresses 0..127 of the page), and `m_last` is on the 128th beat.
- `m_valid`/`m_data` hold stable while `m_ready` is low.
- `nentries` is sampled only at cycle 0. Later changes have no effect on the run.

## Configuration
- `FM_READER_PROFILE_EN` defined: the `stall_cycles` port exists. It counts cycles with `m_valid && !m_ready` during a run, saturates at 0xFFFF, clears on accepted `start` and on reset, and holds its value after `done`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Page 1, nentries_1=5, RAM_LAT=1, `m_ready`=1, start at cycle 0:
  - readaddr 0x80..0x84 on cycles 1–5.
  - Beats on cycles 3–7 in address order, with `m_last` on cycle 7.
  - `done` on cycle 8 with `bx_out`=`bx_in`.
- nentries_0=0, bx_in=4 → `done` on cycle 1, `bx_out`=4, no `enb`, no `m_valid`.
- N=6 with `m_ready` toggling 1,0,0,1,…:
  - All 6 beats arrive in order, each held stable while stalled.
  - Outstanding reads never exceed 3.
  - With the macro defined, `stall_cycles` equals the number of stalled valid cycles.
- nentries_0=200 → exactly 128 beats (addresses 0x00–0x7F), `m_last` on the 128th.
- Assert `reset` in the middle of a 10-entry run after 4 beats:
  - All outputs return to their reset values in the same cycle and `done` never pulses.
  - A fresh run then completes normally.
- `start` pulsed during READ → ignored. `bx_out` reflects only the first run.
